// File: rtl/bidir_link_pkg.sv
// Shared encodings for the half-duplex bidir pad link controller.
package bidir_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_START = 3'd1,
    ST_TX_DATA  = 3'd2,
    ST_TX_STOP  = 3'd3,
    ST_RX_DATA  = 3'd4,
    ST_RX_STOP  = 3'd5,
    ST_RX_DONE  = 3'd6,
    ST_TURN     = 3'd7
  } state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  function automatic logic is_tx_state(input state_t s);
    return (s == ST_TX_START) || (s == ST_TX_DATA) || (s == ST_TX_STOP);
  endfunction

endpackage

// File: rtl/bidir_link_ctrl.sv
// Half-duplex link controller: arbitrates one bidir pad between local tx frames
// and remote rx frames, with a released turnaround gap after every frame.
//
// state       | meaning
// ST_IDLE     | wire idle, accept tx or detect rx start bit
// ST_TX_START | driving start bit
// ST_TX_DATA  | driving DW data bits, LSB first
// ST_TX_STOP  | driving stop bit
// ST_RX_DATA  | sampling DW data bits, LSB first
// ST_RX_STOP  | sampling stop bit
// ST_RX_DONE  | reporting rx_valid or rx_err for one cycle
// ST_TURN     | pad released and ignored for TURN cycles
module bidir_link_ctrl
  import bidir_link_pkg::*;
#(
  parameter int DW   = 8,
  parameter int TURN = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          tx_valid,
  input  logic [DW-1:0] tx_data,
  output logic          tx_ready,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  output logic          rx_err,
  output logic          busy,
  input  logic          pad_i,
  output logic          pad_o,
  output logic          pad_t
);

  localparam int BW = $clog2(DW + 1);
  localparam int TW = $clog2(TURN + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_rx_data;
  logic [BW-1:0] r_bit_cnt;
  logic [TW-1:0] r_turn_cnt;
  logic          r_stop;
  logic          r_pad_o;
  logic          r_pad_t;
  logic          w_xfer;
  logic          w_bit_last;
  logic          w_turn_last;
  logic          w_pad_o_nxt;
  logic          w_pad_t_nxt;

  assign tx_ready    = (r_state == ST_IDLE) && en && (pad_i != START_BIT);
  assign w_xfer      = tx_valid && tx_ready;
  assign w_bit_last  = (r_bit_cnt == BW'(DW - 1));
  assign w_turn_last = (r_turn_cnt == TW'(TURN - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en && (pad_i == START_BIT)) w_state_nxt = ST_RX_DATA;
        else if (w_xfer)                w_state_nxt = ST_TX_START;
      end
      ST_TX_START: w_state_nxt = ST_TX_DATA;
      ST_TX_DATA:  if (w_bit_last) w_state_nxt = ST_TX_STOP;
      ST_TX_STOP:  w_state_nxt = ST_TURN;
      ST_RX_DATA:  if (w_bit_last) w_state_nxt = ST_RX_STOP;
      ST_RX_STOP:  w_state_nxt = ST_RX_DONE;
      ST_RX_DONE:  w_state_nxt = ST_TURN;
      ST_TURN:     if (w_turn_last) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Pad controls are registered from the next state so the wire changes on the edge.
  always_comb begin
    w_pad_t_nxt = !is_tx_state(w_state_nxt);
    case (w_state_nxt)
      ST_TX_START: w_pad_o_nxt = START_BIT;
      ST_TX_DATA:  w_pad_o_nxt = r_shift[0];
      ST_TX_STOP:  w_pad_o_nxt = STOP_BIT;
      default:     w_pad_o_nxt = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_pad_o    <= IDLE_LVL;
      r_pad_t    <= 1'b1;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_turn_cnt <= '0;
      r_stop     <= STOP_BIT;
    end else begin
      r_state    <= w_state_nxt;
      r_pad_o    <= w_pad_o_nxt;
      r_pad_t    <= w_pad_t_nxt;
      r_bit_cnt  <= ((r_state == ST_TX_DATA) || (r_state == ST_RX_DATA)) ? r_bit_cnt + 1'b1 : '0;
      r_turn_cnt <= (r_state == ST_TURN) ? r_turn_cnt + 1'b1 : '0;

      // One register serves both directions: shifts out for tx, shifts in from the MSB for rx.
      if (w_xfer)
        r_shift <= tx_data;
      else if (w_state_nxt == ST_TX_DATA)
        r_shift <= r_shift >> 1;
      else if (r_state == ST_RX_DATA)
        r_shift <= (r_shift >> 1) | (DW'(pad_i) << (DW - 1));

      if (r_state == ST_RX_STOP) begin
        r_stop <= pad_i;
        if (pad_i == STOP_BIT) r_rx_data <= r_shift;
      end
    end
  end

  assign pad_o    = r_pad_o;
  assign pad_t    = r_pad_t;
  assign rx_data  = r_rx_data;
  assign rx_valid = (r_state == ST_RX_DONE) && (r_stop == STOP_BIT);
  assign rx_err   = (r_state == ST_RX_DONE) && (r_stop != STOP_BIT);
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Directed-vector bench for bidir_link_ctrl (DW=8, TURN=2).
module tb_bidir_link_ctrl;

  localparam int DW   = 8;
  localparam int TURN = 2;

  logic          clk = 1'b0;
  logic          nreset;
  logic          en;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_err;
  logic          busy;
  logic          pad_i;
  logic          pad_o;
  logic          pad_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  bidir_link_ctrl #(.DW(DW), .TURN(TURN)) dut (
    .clk(clk), .nreset(nreset), .en(en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .busy(busy),
    .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks sample 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    nreset = 1'b0; en = 1'b0; tx_valid = 1'b0; tx_data = '0; pad_i = 1'b0;
    #1;
    step(); step();
    #1;
    vec_cnt++; if (pad_t !== 1'b1)   begin err_cnt++; $display("FAIL reset_pad_t got %b want 1", pad_t); end
    vec_cnt++; if (pad_o !== 1'b0)   begin err_cnt++; $display("FAIL reset_pad_o got %b want 0", pad_o); end
    vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_ready got %b want 0", tx_ready); end
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    vec_cnt++; if (rx_err !== 1'b0)  begin err_cnt++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    vec_cnt++; if (busy !== 1'b0)    begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    step();
    nreset = 1'b1;
    step();
  endtask

  task automatic test_tx();
    logic [0:9] wave;
    wave = 10'b1101001010;
    en = 1'b1; pad_i = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL tx_ready_c0 got %b want 1", tx_ready); end
    step();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      #1;
      vec_cnt++; if (pad_t !== 1'b0) begin err_cnt++; $display("FAIL tx_pad_t c%0d got %b want 0", i, pad_t); end
      vec_cnt++; if (pad_o !== wave[i-1]) begin err_cnt++; $display("FAIL tx_pad_o c%0d got %b want %b", i, pad_o, wave[i-1]); end
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL tx_busy c%0d got %b want 1", i, busy); end
      step();
    end
    for (int i = 11; i <= 12; i++) begin
      #1;
      vec_cnt++; if (pad_t !== 1'b1) begin err_cnt++; $display("FAIL tx_turn_pad_t c%0d got %b want 1", i, pad_t); end
      vec_cnt++; if (pad_o !== 1'b0) begin err_cnt++; $display("FAIL tx_turn_pad_o c%0d got %b want 0", i, pad_o); end
      vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL tx_turn_ready c%0d got %b want 0", i, tx_ready); end
      step();
    end
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL tx_ready_c13 got %b want 1", tx_ready); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL tx_busy_c13 got %b want 0", busy); end
    step();
  endtask

  task automatic test_rx_frame(input string name, input logic [DW-1:0] data,
                               input logic stop, input logic [DW-1:0] exp_data);
    tx_valid = 1'b0; en = 1'b1; pad_i = 1'b1;
    #1;
    vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL %s_start_ready got %b want 0", name, tx_ready); end
    step();
    for (int k = 0; k < DW; k++) begin
      pad_i = data[k];
      #1;
      vec_cnt++; if (pad_t !== 1'b1) begin err_cnt++; $display("FAIL %s_pad_t bit%0d got %b want 1", name, k, pad_t); end
      vec_cnt++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin
        err_cnt++; $display("FAIL %s_early_pulse bit%0d got v=%b e=%b want 0 0", name, k, rx_valid, rx_err);
      end
      step();
    end
    pad_i = stop;
    #1;
    vec_cnt++; if (pad_t !== 1'b1) begin err_cnt++; $display("FAIL %s_stop_pad_t got %b want 1", name, pad_t); end
    step();
    pad_i = 1'b0;
    #1;
    vec_cnt++; if (rx_valid !== ~stop) begin err_cnt++; $display("FAIL %s_rx_valid got %b want %b", name, rx_valid, ~stop); end
    vec_cnt++; if (rx_err !== stop) begin err_cnt++; $display("FAIL %s_rx_err got %b want %b", name, rx_err, stop); end
    vec_cnt++; if (rx_data !== exp_data) begin err_cnt++; $display("FAIL %s_rx_data got %h want %h", name, rx_data, exp_data); end
    vec_cnt++; if (pad_t !== 1'b1) begin err_cnt++; $display("FAIL %s_done_pad_t got %b want 1", name, pad_t); end
    step();
    for (int i = 0; i < TURN; i++) begin
      pad_i = 1'b1;
      #1;
      vec_cnt++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin
        err_cnt++; $display("FAIL %s_turn_pulse t%0d got v=%b e=%b want 0 0", name, i, rx_valid, rx_err);
      end
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL %s_turn_busy t%0d got %b want 1", name, i, busy); end
      step();
    end
    pad_i = 1'b0;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL %s_idle_busy got %b want 0", name, busy); end
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL %s_idle_ready got %b want 1", name, tx_ready); end
    step();
  endtask

  task automatic test_collision();
    logic [DW-1:0] rx_pat;
    int n;
    rx_pat = 8'hC3;
    en = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; pad_i = 1'b1;
    #1;
    vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL coll_ready_c0 got %b want 0", tx_ready); end
    step();
    for (int k = 0; k < DW; k++) begin
      pad_i = rx_pat[k];
      step();
    end
    pad_i = 1'b0;
    step();
    #1;
    vec_cnt++; if (rx_valid !== 1'b1) begin err_cnt++; $display("FAIL coll_rx_valid got %b want 1", rx_valid); end
    vec_cnt++; if (rx_data !== 8'hC3) begin err_cnt++; $display("FAIL coll_rx_data got %h want c3", rx_data); end
    vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL coll_done_ready got %b want 0", tx_ready); end
    step();
    for (int i = 0; i < TURN; i++) begin
      #1;
      vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL coll_turn_ready t%0d got %b want 0", i, tx_ready); end
      step();
    end
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL coll_idle_ready got %b want 1", tx_ready); end
    step();
    tx_valid = 1'b0;
    #1;
    vec_cnt++; if (pad_t !== 1'b0 || pad_o !== 1'b1) begin
      err_cnt++; $display("FAIL coll_tx_start got t=%b o=%b want 0 1", pad_t, pad_o);
    end
    step();
    #1;
    vec_cnt++; if (pad_o !== 1'b0) begin err_cnt++; $display("FAIL coll_tx_bit0 got %b want 0", pad_o); end
    step();
    #1;
    vec_cnt++; if (pad_o !== 1'b1) begin err_cnt++; $display("FAIL coll_tx_bit1 got %b want 1", pad_o); end
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      step(); #1; n++;
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL coll_drain_timeout got busy=%b want 0 within 30 cycles", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    en = 1'b1; pad_i = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF;
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_ready got %b want 1", tx_ready); end
    step();
    tx_valid = 1'b0;
    repeat (4) step();
    #1;
    vec_cnt++; if (pad_t !== 1'b0 || pad_o !== 1'b1) begin
      err_cnt++; $display("FAIL rstmid_bit3 got t=%b o=%b want 0 1", pad_t, pad_o);
    end
    nreset = 1'b0;
    #1;
    vec_cnt++; if (pad_t !== 1'b1) begin err_cnt++; $display("FAIL rstmid_pad_t got %b want 1", pad_t); end
    vec_cnt++; if (pad_o !== 1'b0) begin err_cnt++; $display("FAIL rstmid_pad_o got %b want 0", pad_o); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL rstmid_rx_data got %h want 00", rx_data); end
    step(); step();
    nreset = 1'b1;
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_release_ready got %b want 1", tx_ready); end
    step();
  endtask

  task automatic test_en();
    logic [0:9] wave;
    logic [DW-1:0] d;
    d = 8'h96;
    wave[0] = 1'b1;
    for (int k = 0; k < DW; k++) wave[1+k] = d[k];
    wave[9] = 1'b0;
    en = 1'b0; tx_valid = 1'b1; tx_data = d; pad_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL en_off_ready c%0d got %b want 0", i, tx_ready); end
      step();
      #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL en_off_busy c%0d got %b want 0", i, busy); end
    end
    step();
    pad_i = 1'b0; en = 1'b1;
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL en_on_ready got %b want 1", tx_ready); end
    step();
    tx_valid = 1'b0; en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      vec_cnt++; if (pad_t !== 1'b0 || pad_o !== wave[i-1]) begin
        err_cnt++; $display("FAIL en_tx c%0d got t=%b o=%b want 0 %b", i, pad_t, pad_o, wave[i-1]);
      end
      step();
    end
    repeat (TURN) step();
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL en_end_busy got %b want 0", busy); end
    vec_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL en_end_ready got %b want 0", tx_ready); end
    en = 1'b1;
    #1;
    vec_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL en_reenable_ready got %b want 1", tx_ready); end
    step();
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_frame("rx_good", 8'h3C, 1'b0, 8'h3C);
    test_rx_frame("rx_err", 8'h81, 1'b1, 8'h3C);
    test_collision();
    test_reset_mid();
    test_en();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
